// File: rtl/id_operand_fetch_pkg.sv
// Shared widths, the zero-register index, the reset level and the forward-source encoding
// used by the ID-stage operand fetch unit.
package id_operand_fetch_pkg;

    localparam int RegWidth        = 32;
    localparam int RegAddrBusWidth = 5;

    // Register 0 is hard-wired to zero and never takes part in forwarding or hazards.
    localparam int ZeroRegIdx = 0;

    // Level of rst_n that resets the block.
    localparam logic RstActive = 1'b0;

    // Where a resolved operand came from.
    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_RF   = 3'd4
    } fwd_sel_e;

endpackage

// File: rtl/id_operand_fetch_fwd_mux.sv
// Per-source forward selector: picks the youngest in-flight producer of a source register.
// It also flags a source that matches a load still in EX, whose data does not exist yet.
module id_operand_fetch_fwd_mux
    import id_operand_fetch_pkg::*;
#(
    parameter int DATA_W = RegWidth,
    parameter int ADDR_W = RegAddrBusWidth
) (
    input  logic              src_en,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] operand,
    output logic              ex_load_hit
);

    fwd_sel_e sel;
    logic     src_live;

    // Priority select EX -> MEM -> WB -> regfile; WB is needed because the regfile write
    // only lands at the clock edge, so the same-cycle read is stale.
    always_comb begin
        src_live    = src_en && (src_addr != ADDR_W'(ZeroRegIdx));
        ex_load_hit = src_live && ex_wreg && ex_is_load && (src_addr == ex_waddr);
        sel         = FWD_ZERO;
        if (src_live) begin
            if (ex_wreg && !ex_is_load && (src_addr == ex_waddr)) begin
                sel = FWD_EX;
            end else if (mem_wreg && (src_addr == mem_waddr)) begin
                sel = FWD_MEM;
            end else if (wb_wreg && (src_addr == wb_waddr)) begin
                sel = FWD_WB;
            end else begin
                sel = FWD_RF;
            end
        end
    end

    // Data mux driven by the selected source.
    always_comb begin
        operand = '0;
        case (sel)
            FWD_EX:  operand = ex_wdata;
            FWD_MEM: operand = mem_wdata;
            FWD_WB:  operand = wb_wdata;
            FWD_RF:  operand = rf_rdata;
            default: operand = '0;
        endcase
    end

endmodule

// File: rtl/id_operand_fetch.sv
// ID-stage operand fetch: drives the regfile read ports, resolves RAW hazards by forwarding,
// inserts one bubble on a load-use hazard and registers operands into ID/EX.
module id_operand_fetch
    import id_operand_fetch_pkg::*;
#(
    parameter int DATA_W = RegWidth,
    parameter int ADDR_W = RegAddrBusWidth,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_rs_en,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic              id_rt_en,
    input  logic [ADDR_W-1:0] id_rt_addr,
    output logic              re1,
    output logic [ADDR_W-1:0] raddr1,
    input  logic [DATA_W-1:0] rdata1,
    output logic              re2,
    output logic [ADDR_W-1:0] raddr2,
    input  logic [DATA_W-1:0] rdata2,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall_req,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DATA_W-1:0] op1_res;
    logic [DATA_W-1:0] op2_res;
    logic              rs_load_hit;
    logic              rt_load_hit;
    logic              luh;

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_op1_q,   ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q,   ex_op2_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    id_operand_fetch_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rs (
        .src_en      (id_rs_en),
        .src_addr    (id_rs_addr),
        .ex_wreg     (ex_wreg),
        .ex_waddr    (ex_waddr),
        .ex_wdata    (ex_wdata),
        .ex_is_load  (ex_is_load),
        .mem_wreg    (mem_wreg),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wb_wreg     (wb_wreg),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .rf_rdata    (rdata1),
        .operand     (op1_res),
        .ex_load_hit (rs_load_hit)
    );

    id_operand_fetch_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rt (
        .src_en      (id_rt_en),
        .src_addr    (id_rt_addr),
        .ex_wreg     (ex_wreg),
        .ex_waddr    (ex_waddr),
        .ex_wdata    (ex_wdata),
        .ex_is_load  (ex_is_load),
        .mem_wreg    (mem_wreg),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wb_wreg     (wb_wreg),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .rf_rdata    (rdata2),
        .operand     (op2_res),
        .ex_load_hit (rt_load_hit)
    );

    // Regfile read ports and hazard/stall signalling, all combinational.
    always_comb begin
        re1       = id_valid & id_rs_en;
        raddr1    = id_rs_addr;
        re2       = id_valid & id_rt_en;
        raddr2    = id_rt_addr;
        luh       = id_valid & (rs_load_hit | rt_load_hit);
        stall_req = luh | ex_hold;
    end

    // Next ID/EX state: flush beats hold, hold beats the load-use bubble.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_op1_d    = ex_op1_q;
        ex_op2_d    = ex_op2_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_op1_d   = '0;
            ex_op2_d   = '0;
        end else if (ex_hold) begin
            ex_valid_d = ex_valid_q;
        end else if (luh) begin
            ex_valid_d = 1'b0;
            ex_op1_d   = '0;
            ex_op2_d   = '0;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d = id_valid;
            ex_op1_d   = op1_res;
            ex_op2_d   = op2_res;
        end
    end

    // ID/EX register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n == RstActive) begin
            ex_valid_q  <= 1'b0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op1_q    <= ex_op1_d;
            ex_op2_q    <= ex_op2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_op1    = ex_op1_q;
    assign ex_op2    = ex_op2_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Scoreboard bench for id_operand_fetch: a driver issues one directed vector per cycle and
// queues its hand-computed result; a monitor checks the combinational outputs in that cycle
// and the ID/EX outputs after the following edge. A second instance with a 4-bit counter
// exposes stall-counter saturation.
module tb_id_operand_fetch;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        string       name;
        logic        rst_n, id_valid, rs_en, rt_en;
        logic [4:0]  rs, rt;
        logic [31:0] rdata1, rdata2;
        logic        ex_wreg, ex_is_load;
        logic [4:0]  ex_waddr;
        logic [31:0] ex_wdata;
        logic        mem_wreg;
        logic [4:0]  mem_waddr;
        logic [31:0] mem_wdata;
        logic        wb_wreg;
        logic [4:0]  wb_waddr;
        logic [31:0] wb_wdata;
        logic        ex_hold, flush;
        logic        e_stall, e_valid;
        logic [31:0] e_op1, e_op2;
        logic [15:0] e_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0, id_rs_en = 1'b0, id_rt_en = 1'b0;
    logic [AW-1:0] id_rs_addr = '0, id_rt_addr = '0;
    logic [DW-1:0] rdata1 = '0, rdata2 = '0;
    logic          ex_wreg = 1'b0, ex_is_load = 1'b0, mem_wreg = 1'b0, wb_wreg = 1'b0;
    logic [AW-1:0] ex_waddr = '0, mem_waddr = '0, wb_waddr = '0;
    logic [DW-1:0] ex_wdata = '0, mem_wdata = '0, wb_wdata = '0;
    logic          ex_hold = 1'b0, flush = 1'b0;

    logic          re1, re2, stall_req, ex_valid;
    logic [AW-1:0] raddr1, raddr2;
    logic [DW-1:0] ex_op1, ex_op2;
    logic [15:0]   stall_cnt;

    logic          s_re1, s_re2, s_stall_req, s_ex_valid;
    logic [AW-1:0] s_raddr1, s_raddr2;
    logic [DW-1:0] s_ex_op1, s_ex_op2;
    logic [3:0]    s_stall_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t q[$];
    vec_t v;

    always #5 clk = ~clk;

    id_operand_fetch #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_en(id_rs_en), .id_rs_addr(id_rs_addr), .id_rt_en(id_rt_en), .id_rt_addr(id_rt_addr),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_wreg(wb_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_hold(ex_hold), .flush(flush), .stall_req(stall_req), .ex_valid(ex_valid),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .stall_cnt(stall_cnt)
    );

    id_operand_fetch #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_en(id_rs_en), .id_rs_addr(id_rs_addr), .id_rt_en(id_rt_en), .id_rt_addr(id_rt_addr),
        .re1(s_re1), .raddr1(s_raddr1), .rdata1(rdata1), .re2(s_re2), .raddr2(s_raddr2), .rdata2(rdata2),
        .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_wreg(wb_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_hold(ex_hold), .flush(flush), .stall_req(s_stall_req), .ex_valid(s_ex_valid),
        .ex_op1(s_ex_op1), .ex_op2(s_ex_op2), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string nm, input string what, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", nm, what, act, exp);
        end
    endtask

    task automatic clr();
        v.rst_n = 1'b1; v.id_valid = 1'b1; v.rs_en = 1'b0; v.rt_en = 1'b0;
        v.rs = '0; v.rt = '0; v.rdata1 = '0; v.rdata2 = '0;
        v.ex_wreg = 1'b0; v.ex_is_load = 1'b0; v.ex_waddr = '0; v.ex_wdata = '0;
        v.mem_wreg = 1'b0; v.mem_waddr = '0; v.mem_wdata = '0;
        v.wb_wreg = 1'b0; v.wb_waddr = '0; v.wb_wdata = '0;
        v.ex_hold = 1'b0; v.flush = 1'b0;
    endtask

    task automatic issue(input string nm, input logic es, input logic ev,
                         input logic [31:0] e1, input logic [31:0] e2, input logic [15:0] ec);
        @(posedge clk);
        #1;
        v.name = nm; v.e_stall = es; v.e_valid = ev; v.e_op1 = e1; v.e_op2 = e2; v.e_cnt = ec;
        rst_n = v.rst_n; id_valid = v.id_valid;
        id_rs_en = v.rs_en; id_rs_addr = v.rs; id_rt_en = v.rt_en; id_rt_addr = v.rt;
        rdata1 = v.rdata1; rdata2 = v.rdata2;
        ex_wreg = v.ex_wreg; ex_waddr = v.ex_waddr; ex_wdata = v.ex_wdata; ex_is_load = v.ex_is_load;
        mem_wreg = v.mem_wreg; mem_waddr = v.mem_waddr; mem_wdata = v.mem_wdata;
        wb_wreg = v.wb_wreg; wb_waddr = v.wb_waddr; wb_wdata = v.wb_wdata;
        ex_hold = v.ex_hold; flush = v.flush;
        q.push_back(v);
    endtask

    // Monitor: same-cycle combinational checks, then registered checks one edge later.
    initial begin
        vec_t cur, prev;
        bit   have_prev;
        logic [15:0] sat_exp;
        logic [11:0] port_exp;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (have_prev) begin
                sat_exp = (prev.e_cnt > 16'd15) ? 16'd15 : prev.e_cnt;
                chk(prev.name, "ex_valid",      {63'd0, ex_valid},   {63'd0, prev.e_valid});
                chk(prev.name, "ex_op1",        {32'd0, ex_op1},     {32'd0, prev.e_op1});
                chk(prev.name, "ex_op2",        {32'd0, ex_op2},     {32'd0, prev.e_op2});
                chk(prev.name, "stall_cnt",     {48'd0, stall_cnt},  {48'd0, prev.e_cnt});
                chk(prev.name, "sat.ex_valid",  {63'd0, s_ex_valid}, {63'd0, prev.e_valid});
                chk(prev.name, "sat.ops",       {s_ex_op1, s_ex_op2}, {prev.e_op1, prev.e_op2});
                chk(prev.name, "sat.stall_cnt", {60'd0, s_stall_cnt}, sat_exp[3:0] == sat_exp[3:0] ? {48'd0, sat_exp} : 64'd0);
            end
            have_prev = 1'b0;
            if (q.size() > 0) begin
                cur = q.pop_front();
                port_exp = {cur.id_valid & cur.rs_en, cur.rs, cur.id_valid & cur.rt_en, cur.rt};
                chk(cur.name, "stall_req",     {63'd0, stall_req},   {63'd0, cur.e_stall});
                chk(cur.name, "sat.stall_req", {63'd0, s_stall_req}, {63'd0, cur.e_stall});
                chk(cur.name, "rf_ports",      {52'd0, re1, raddr1, re2, raddr2},         {52'd0, port_exp});
                chk(cur.name, "sat.rf_ports",  {52'd0, s_re1, s_raddr1, s_re2, s_raddr2}, {52'd0, port_exp});
                prev      = cur;
                have_prev = 1'b1;
            end
        end
    end

    // Driver: directed vectors, one per cycle, with hand-computed results.
    initial begin
        clr(); v.rst_n = 1'b0; v.id_valid = 1'b0;
        issue("reset0", 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
        issue("reset1", 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);

        clr(); v.rs_en = 1'b1; v.rs = 5'd5; v.rdata1 = 32'h1234;
        issue("plain_read", 1'b0, 1'b1, 32'h0000_1234, 32'h0, 16'd0);

        clr(); v.rt_en = 1'b1; v.rt = 5'd3; v.rdata2 = 32'hDEAD;
        v.ex_wreg = 1'b1; v.ex_waddr = 5'd3; v.ex_wdata = 32'hA;
        v.mem_wreg = 1'b1; v.mem_waddr = 5'd3; v.mem_wdata = 32'hB;
        v.wb_wreg = 1'b1; v.wb_waddr = 5'd3; v.wb_wdata = 32'hC;
        issue("fwd_ex", 1'b0, 1'b1, 32'h0, 32'hA, 16'd0);
        v.ex_wreg = 1'b0;
        issue("fwd_mem", 1'b0, 1'b1, 32'h0, 32'hB, 16'd0);
        v.mem_wreg = 1'b0;
        issue("fwd_wb", 1'b0, 1'b1, 32'h0, 32'hC, 16'd0);
        v.wb_wreg = 1'b0;
        issue("fwd_rf", 1'b0, 1'b1, 32'h0, 32'hDEAD, 16'd0);

        clr(); v.rs_en = 1'b1; v.rs = 5'd0; v.rdata1 = 32'h99;
        v.ex_wreg = 1'b1; v.ex_waddr = 5'd0; v.ex_wdata = 32'hFFFF;
        issue("zero_reg", 1'b0, 1'b1, 32'h0, 32'h0, 16'd0);
        v.ex_is_load = 1'b1; v.rt_en = 1'b1; v.rt = 5'd0;
        issue("zero_reg_load", 1'b0, 1'b1, 32'h0, 32'h0, 16'd0);

        clr(); v.rs_en = 1'b1; v.rs = 5'd2; v.rdata1 = 32'h22; v.rt_en = 1'b1; v.rt = 5'd7; v.rdata2 = 32'h11;
        v.ex_wreg = 1'b1; v.ex_is_load = 1'b1; v.ex_waddr = 5'd7; v.ex_wdata = 32'h77;
        issue("luh_bubble", 1'b1, 1'b0, 32'h0, 32'h0, 16'd1);
        v.ex_wreg = 1'b0; v.ex_is_load = 1'b0;
        v.mem_wreg = 1'b1; v.mem_waddr = 5'd7; v.mem_wdata = 32'h55;
        issue("luh_mem_fwd", 1'b0, 1'b1, 32'h22, 32'h55, 16'd1);

        clr(); v.rs_en = 1'b1; v.rs = 5'd7;
        v.ex_wreg = 1'b1; v.ex_is_load = 1'b1; v.ex_waddr = 5'd7;
        issue("luh_rs_a", 1'b1, 1'b0, 32'h0, 32'h0, 16'd2);
        issue("luh_rs_b", 1'b1, 1'b0, 32'h0, 32'h0, 16'd3);

        clr(); v.rs_en = 1'b1; v.rs = 5'd1; v.rdata1 = 32'h10;
        issue("load_valid", 1'b0, 1'b1, 32'h10, 32'h0, 16'd3);
        clr(); v.rt_en = 1'b1; v.rt = 5'd7; v.ex_wreg = 1'b1; v.ex_is_load = 1'b1; v.ex_waddr = 5'd7;
        v.ex_hold = 1'b1; v.flush = 1'b1;
        issue("flush_beats_hold", 1'b1, 1'b0, 32'h0, 32'h0, 16'd3);

        clr(); v.rs_en = 1'b1; v.rs = 5'd4; v.rdata1 = 32'h44;
        issue("pre_hold", 1'b0, 1'b1, 32'h44, 32'h0, 16'd3);
        v.ex_wreg = 1'b1; v.ex_is_load = 1'b1; v.ex_waddr = 5'd4; v.ex_hold = 1'b1;
        issue("hold_with_luh", 1'b1, 1'b1, 32'h44, 32'h0, 16'd3);
        clr(); v.rs_en = 1'b1; v.rs = 5'd6; v.rdata1 = 32'h66; v.ex_hold = 1'b1;
        issue("hold_only", 1'b1, 1'b1, 32'h44, 32'h0, 16'd3);

        clr(); v.rs_en = 1'b1; v.rs = 5'd5; v.rdata1 = 32'h1234; v.rst_n = 1'b0;
        issue("mid_reset", 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
        v.rst_n = 1'b1;
        issue("post_reset", 1'b0, 1'b1, 32'h1234, 32'h0, 16'd0);

        clr(); v.rs_en = 1'b1; v.rs = 5'd9; v.ex_wreg = 1'b1; v.ex_is_load = 1'b1; v.ex_waddr = 5'd9;
        for (int k = 1; k <= 17; k++) begin
            issue($sformatf("luh_sat_%0d", k), 1'b1, 1'b0, 32'h0, 32'h0, 16'(k));
        end
        v.id_valid = 1'b0; v.rs_en = 1'b0;
        issue("no_id_valid", 1'b0, 1'b0, 32'h0, 32'h0, 16'd17);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- ID-stage operand fetch unit. It is the read-side master of the register file: it drives the register-file read ports (re1/raddr1, re2/raddr2) and consumes rdata1/rdata2.
- It resolves RAW hazards by forwarding from the EX, MEM and WB stages.
- It detects load-use hazards and inserts a one-cycle bubble.
- It registers the resolved operands into the ID/EX pipeline register with hold and flush control.

Parameters:
DATA_W, 32, operand/register width (matches RegWidth)
ADDR_W, 5, register address width (matches RegAddrBusWidth)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
id_valid  input  1  instruction in ID is valid
id_rs_en  input  1  instruction reads rs
id_rs_addr  input  ADDR_W  rs index
id_rt_en  input  1  instruction reads rt
id_rt_addr  input  ADDR_W  rt index
re1  output  1  regfile read enable, port 1 (= id_valid & id_rs_en)
raddr1  output  ADDR_W  regfile read address, port 1 (= id_rs_addr)
rdata1  input  DATA_W  regfile read data, port 1 (combinational)
re2  output  1  regfile read enable, port 2 (= id_valid & id_rt_en)
raddr2  output  ADDR_W  regfile read address, port 2 (= id_rt_addr)
rdata2  input  DATA_W  regfile read data, port 2
ex_wreg  input  1  EX-stage instruction writes a register
ex_waddr  input  ADDR_W  EX destination
ex_wdata  input  DATA_W  EX result
ex_is_load  input  1  EX instruction is a load (data not yet available)
mem_wreg  input  1  MEM-stage writes a register
mem_waddr  input  ADDR_W  MEM destination
mem_wdata  input  DATA_W  MEM result
wb_wreg  input  1  WB write enable (same signal as regfile we)
wb_waddr  input  ADDR_W  WB destination
wb_wdata  input  DATA_W  WB data
ex_hold  input  1  downstream stall; hold ID/EX register
flush  input  1  branch/exception flush of ID/EX
stall_req  output  1  ID/IF must hold current instruction
ex_valid  output  1  registered: ID/EX holds a valid instruction
ex_op1  output  DATA_W  registered resolved rs operand
ex_op2  output  DATA_W  registered resolved rt operand
stall_cnt  output  CNT_W  saturating count of load-use bubble cycles

Behaviour:
- Read port outputs are combinational pass-through, as listed in Ports.
- Operand resolution (combinational, per source):
  - If the source is disabled or its address is 0, the operand is 0. Register 0 is never forwarded, even if a stage reports a write to it.
  - Otherwise, take the first match in this order: EX (ex_wreg & addr==ex_waddr & !ex_is_load) -> MEM -> WB -> regfile rdata.
  - The WB forward is mandatory. A regfile write lands only at the clock edge, so same-cycle read data is stale.
- Load-use hazard: luh = id_valid & ex_wreg & ex_is_load & ex_waddr!=0 & ((id_rs_en & id_rs_addr==ex_waddr) | (id_rt_en & id_rt_addr==ex_waddr)).
- stall_req = luh | ex_hold. It is combinational.
- ID/EX register update, evaluated at each edge in priority order:
  1. !rst_n: ex_valid=0, ex_op1=0, ex_op2=0, stall_cnt=0.
  2. flush: ex_valid=0, ex_op1=0, ex_op2=0. Flush wins over ex_hold and luh.
  3. ex_hold: all registers hold.
  4. luh: load a bubble (ex_valid=0, ops=0); stall_cnt+1, saturating at all-ones.
  5. Otherwise: ex_valid=id_valid, ex_op1/ex_op2 = resolved operands.
- Latency: one cycle from ID inputs to ex_* outputs.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in MEM and its data is forwarded from MEM.
- Simultaneous luh and ex_hold: hold takes effect, and stall_cnt does not increment.
- Reset mid-operation: on the reset edge all registered state returns to its reset value.

Decomposition:
- Shared defines: DATA_W/ADDR_W (RegWidth, RegAddrBusWidth), the zero-register index constant, and the reset-active level constant.
- Natural sub-module: fwd_mux. It is the per-source combinational priority forward selector and is instantiated twice, for rs and rt.

Test Plan:
- Plain read: regfile r5=0x1234, id rs=5, no hazards -> next cycle ex_op1=0x00001234, ex_valid=1.
- Forward priority: EX writes r3=0xA, MEM r3=0xB, WB r3=0xC, rt=3 -> ex_op2=0xA. Drop EX -> 0xB. Drop MEM -> 0xC.
- Zero register: rs=0, EX writes r0=0xFFFF -> ex_op1=0. No stall even if EX is a load to r0.
- Load-use: EX is a load to r7, ID reads rt=7:
  - First cycle: stall_req=1, next ex_valid=0, stall_cnt=1.
  - Following cycle: MEM forwards 0x55 -> ex_op2=0x55, ex_valid=1.
- Flush beats hold: ex_hold=1 and flush=1 with ex_valid=1 -> next ex_valid=0 and ops=0.
- Reset: assert rst_n=0 mid-stream with ex_valid=1 and stall_cnt=3 -> after the edge, all outputs are 0. Separately, force stall_cnt to 0xFFFF and trigger luh -> stays 0xFFFF.
